// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - sequences ADD operand fetches over one memory port
// Optional result writeback to REGISTER1 is enabled by defining ALU_SEQ_WRITEBACK_EN.
module alu_operand_sequencer #(
    parameter logic [15:0] REG_BASE = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  ALUK,
    input  logic [1:0]  SR2SEL,
    input  logic [2:0]  REGISTER1,
    input  logic [2:0]  REGISTER2,
    input  logic [7:0]  DATA,
    input  logic [6:0]  ADDRESS,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [15:0] MEM_RDATA,
    output logic        MEM_WR,
    output logic [15:0] MEM_WDATA,
    output logic [15:0] SR1OUT,
    output logic [15:0] SR2OUT,
    output logic [15:0] ANSWER,
    output logic        CARRY,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        RD3  = 3'd3,
        RD4  = 3'd4,
        EXEC = 3'd5,
        WB   = 3'd6,
        FIN  = 3'd7
    } state_t;

    localparam logic [1:0] ALUK_ADD = 2'b11;
    localparam logic [1:0] MODE_REG = 2'b00;
    localparam logic [1:0] MODE_IMM = 2'b01;
    localparam logic [1:0] MODE_DIR = 2'b10;
    localparam logic [1:0] MODE_IND = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  r1_q, r1_d;
    logic [2:0]  r2_q, r2_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] sr1_q, sr1_d;
    logic [15:0] sr2_q, sr2_d;
    logic [15:0] ans_q, ans_d;
    logic        carry_q, carry_d;
    logic        err_q, err_d;

    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        busy;
    logic        done;
`ifdef ALU_SEQ_WRITEBACK_EN
    logic        mem_wr;
    logic [15:0] mem_wdata;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            r1_q    <= 3'd0;
            r2_q    <= 3'd0;
            data_q  <= 8'h00;
            addr_q  <= 7'h00;
            sr1_q   <= 16'h0000;
            sr2_q   <= 16'h0000;
            ans_q   <= 16'h0000;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            ans_q   <= ans_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        data_d   = data_q;
        addr_d   = addr_q;
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        ans_d    = ans_q;
        carry_d  = carry_q;
        err_d    = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        busy     = (state_q != IDLE);
        done     = 1'b0;
`ifdef ALU_SEQ_WRITEBACK_EN
        mem_wr    = 1'b0;
        mem_wdata = 16'h0000;
`endif

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (ALUK == ALUK_ADD) begin
                        mode_d  = SR2SEL;
                        r1_d    = REGISTER1;
                        r2_d    = REGISTER2;
                        data_d  = DATA;
                        addr_d  = ADDRESS;
                        state_d = RD1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD1: begin
                mem_rd   = 1'b1;
                mem_addr = REG_BASE + {13'd0, r1_q};
                state_d  = RD2;
            end
            RD2: begin
                sr1_d = MEM_RDATA;
                case (mode_q)
                    MODE_IMM: begin
                        sr2_d   = {8'h00, data_q};
                        state_d = EXEC;
                    end
                    MODE_REG: begin
                        mem_rd   = 1'b1;
                        mem_addr = REG_BASE + {13'd0, r2_q};
                        state_d  = RD3;
                    end
                    MODE_DIR: begin
                        mem_rd   = 1'b1;
                        mem_addr = {9'h000, addr_q};
                        state_d  = RD3;
                    end
                    default: begin
                        // Indirect pointers may only live in R0 or R1.
                        mem_rd   = 1'b1;
                        mem_addr = REG_BASE + {15'd0, r2_q[0]};
                        state_d  = RD3;
                    end
                endcase
            end
            RD3: begin
                if (mode_q == MODE_IND) begin
                    mem_rd   = 1'b1;
                    mem_addr = MEM_RDATA;
                    state_d  = RD4;
                end else begin
                    sr2_d   = MEM_RDATA;
                    state_d = EXEC;
                end
            end
            RD4: begin
                sr2_d   = MEM_RDATA;
                state_d = EXEC;
            end
            EXEC: begin
                {carry_d, ans_d} = {1'b0, sr1_q} + {1'b0, sr2_q};
`ifdef ALU_SEQ_WRITEBACK_EN
                state_d = WB;
`else
                state_d = FIN;
`endif
            end
`ifdef ALU_SEQ_WRITEBACK_EN
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = REG_BASE + {13'd0, r1_q};
                mem_wdata = ans_q;
                state_d   = FIN;
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MEM_RD   = mem_rd;
    assign MEM_ADDR = mem_addr;
    assign SR1OUT   = sr1_q;
    assign SR2OUT   = sr2_q;
    assign ANSWER   = ans_q;
    assign CARRY    = carry_q;
    assign BUSY     = busy;
    assign DONE     = done;
    assign ERR      = err_q;
`ifdef ALU_SEQ_WRITEBACK_EN
    assign MEM_WR    = mem_wr;
    assign MEM_WDATA = mem_wdata;
`else
    assign MEM_WR    = 1'b0;
    assign MEM_WDATA = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed bench for alu_operand_sequencer
module tb_alu_operand_sequencer;

`ifdef ALU_SEQ_WRITEBACK_EN
    localparam int WBX = 1;
`else
    localparam int WBX = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  ALUK = 2'b00;
    logic [1:0]  SR2SEL = 2'b00;
    logic [2:0]  REGISTER1 = 3'd0;
    logic [2:0]  REGISTER2 = 3'd0;
    logic [7:0]  DATA = 8'h00;
    logic [6:0]  ADDRESS = 7'h00;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic [15:0] MEM_RDATA = 16'h0000;
    logic        MEM_WR;
    logic [15:0] MEM_WDATA;
    logic [15:0] SR1OUT, SR2OUT, ANSWER;
    logic        CARRY, BUSY, DONE, ERR;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [15:0] pre_data = 16'h0000;
    logic [15:0] rd_log [0:255];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int port_err = 0;

    alu_operand_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ALUK(ALUK), .SR2SEL(SR2SEL),
        .REGISTER1(REGISTER1), .REGISTER2(REGISTER2), .DATA(DATA), .ADDRESS(ADDRESS),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDATA(MEM_RDATA), .MEM_WR(MEM_WR),
        .MEM_WDATA(MEM_WDATA), .SR1OUT(SR1OUT), .SR2OUT(SR2OUT), .ANSWER(ANSWER),
        .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_RD) begin
            MEM_RDATA <= mem[MEM_ADDR[7:0]];
            rd_log[rd_cnt[7:0]] <= MEM_ADDR;
            rd_cnt <= rd_cnt + 1;
        end
        if (MEM_WR) begin
            mem[MEM_ADDR[7:0]] <= MEM_WDATA;
            wr_cnt <= wr_cnt + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
        if (DONE) done_cnt <= done_cnt + 1;
        if (MEM_RD && MEM_WR) port_err <= port_err + 1;
        if (!MEM_RD && !MEM_WR && MEM_ADDR != 16'h0000) port_err <= port_err + 1;
    end

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] aluk, input logic [1:0] mode,
                           input logic [2:0] r1, input logic [2:0] r2,
                           input logic [7:0] dat, input logic [6:0] adr,
                           input int pulse_at, input int reset_at,
                           output int lat, output logic busy1);
        lat = 0;
        busy1 = 1'b0;
        @(negedge CLK);
        START = 1'b1; ALUK = aluk; SR2SEL = mode;
        REGISTER1 = r1; REGISTER2 = r2; DATA = dat; ADDRESS = adr;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            START = (n == pulse_at);
            if (n == 1) busy1 = BUSY;
            if (n == reset_at) begin
                RESET = 1'b1;
                break;
            end
            if (DONE === 1'b1) begin
                lat = n;
                break;
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA, SR1OUT, SR2OUT, ANSWER, CARRY, BUSY, DONE, ERR} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h rd=%b wr=%b ans=%h busy=%b required all zero",
                     MEM_ADDR, MEM_RD, MEM_WR, ANSWER, BUSY);
        end
        RESET = 1'b0;
    endtask

    task automatic test_immediate;
        int lat;
        logic b1;
        logic [15:0] exp_mem;
        poke(8'd2, 16'h0005);
        run_cmd(2'b11, 2'b01, 3'd2, 3'd0, 8'h12, 7'h00, 0, 0, lat, b1);
        checks++;
        if (lat != 4 + WBX) begin errors++; $display("FAIL imm_latency: got %0d required %0d", lat, 4 + WBX); end
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL imm_busy_rd1: got %b required 1", b1); end
        checks++;
        if (ANSWER !== 16'h0017 || CARRY !== 1'b0) begin
            errors++; $display("FAIL imm_answer: got %h/%b required 0017/0", ANSWER, CARRY);
        end
        checks++;
        if (SR1OUT !== 16'h0005 || SR2OUT !== 16'h0012) begin
            errors++; $display("FAIL imm_operands: got %h %h required 0005 0012", SR1OUT, SR2OUT);
        end
        exp_mem = (WBX == 1) ? 16'h0017 : 16'h0005;
        @(negedge CLK);
        checks++;
        if (mem[2] !== exp_mem) begin errors++; $display("FAIL imm_writeback: got %h required %h", mem[2], exp_mem); end
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ANSWER !== 16'h0017) begin
            errors++; $display("FAIL imm_after: got busy=%b done=%b ans=%h required 0 0 0017", BUSY, DONE, ANSWER);
        end
    endtask

    task automatic test_register;
        int lat, r0;
        logic b1;
        poke(8'd1, 16'h1234);
        poke(8'd6, 16'h0101);
        r0 = rd_cnt;
        run_cmd(2'b11, 2'b00, 3'd1, 3'd6, 8'h00, 7'h00, 0, 0, lat, b1);
        checks++;
        if (lat != 5 + WBX) begin errors++; $display("FAIL reg_latency: got %0d required %0d", lat, 5 + WBX); end
        checks++;
        if (SR1OUT !== 16'h1234 || SR2OUT !== 16'h0101 || ANSWER !== 16'h1335) begin
            errors++; $display("FAIL reg_values: got %h %h %h required 1234 0101 1335", SR1OUT, SR2OUT, ANSWER);
        end
        checks++;
        if (rd_cnt - r0 != 2 || rd_log[r0[7:0]] !== 16'd1 || rd_log[r0[7:0] + 8'd1] !== 16'd6) begin
            errors++; $display("FAIL reg_reads: got n=%0d required reads 1,6", rd_cnt - r0);
        end
    endtask

    task automatic test_direct_wrap_start_while_busy;
        int lat, r0;
        logic b1;
        poke(8'd0, 16'hFFFF);
        poke(8'h30, 16'h0002);
        r0 = rd_cnt;
        run_cmd(2'b11, 2'b10, 3'd0, 3'd0, 8'h00, 7'h30, 2, 0, lat, b1);
        checks++;
        if (lat != 5 + WBX) begin errors++; $display("FAIL dir_latency: got %0d required %0d", lat, 5 + WBX); end
        checks++;
        if (ANSWER !== 16'h0001 || CARRY !== 1'b1) begin
            errors++; $display("FAIL dir_wrap: got %h/%b required 0001/1", ANSWER, CARRY);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || rd_cnt - r0 != 2 || rd_log[r0[7:0] + 8'd1] !== 16'h0030) begin
            errors++; $display("FAIL busy_start_ignored: got busy=%b reads=%0d required 0 and 2", BUSY, rd_cnt - r0);
        end
    endtask

    task automatic test_indirect;
        int lat, r0;
        logic b1;
        poke(8'd3, 16'h0010);
        poke(8'd1, 16'h0040);
        poke(8'h40, 16'h0102);
        r0 = rd_cnt;
        run_cmd(2'b11, 2'b11, 3'd3, 3'd5, 8'h00, 7'h00, 0, 0, lat, b1);
        checks++;
        if (lat != 6 + WBX) begin errors++; $display("FAIL ind_latency: got %0d required %0d", lat, 6 + WBX); end
        checks++;
        if (SR1OUT !== 16'h0010 || SR2OUT !== 16'h0102 || ANSWER !== 16'h0112) begin
            errors++; $display("FAIL ind_values: got %h %h %h required 0010 0102 0112", SR1OUT, SR2OUT, ANSWER);
        end
        checks++;
        if (rd_cnt - r0 != 3 || rd_log[r0[7:0]] !== 16'd3 || rd_log[r0[7:0] + 8'd1] !== 16'd1
            || rd_log[r0[7:0] + 8'd2] !== 16'h0040) begin
            errors++; $display("FAIL ind_reads: got n=%0d required reads 3,1,40", rd_cnt - r0);
        end
    endtask

    task automatic test_illegal_op;
        int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(negedge CLK);
        START = 1'b1; ALUK = 2'b01; SR2SEL = 2'b00;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL err_pulse: got err=%b busy=%b required 1 0", ERR, BUSY);
        end
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b0 || BUSY !== 1'b0 || rd_cnt != r0 || wr_cnt != w0) begin
            errors++; $display("FAIL err_after: got err=%b busy=%b reads=%0d writes=%0d required 0 0 0 0",
                               ERR, BUSY, rd_cnt - r0, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid_command;
        int lat, d0, w0;
        logic b1;
        poke(8'd3, 16'h0010);
        poke(8'd1, 16'h0040);
        poke(8'h40, 16'h0102);
        d0 = done_cnt;
        w0 = wr_cnt;
        run_cmd(2'b11, 2'b11, 3'd3, 3'd1, 8'h00, 7'h00, 0, 3, lat, b1);
        @(negedge CLK);
        checks++;
        if ({MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA, SR1OUT, SR2OUT, ANSWER, CARRY, BUSY, DONE, ERR} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got sr1=%h busy=%b rd=%b required all zero", SR1OUT, BUSY, MEM_RD);
        end
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (done_cnt != d0 || wr_cnt != w0) begin
            errors++; $display("FAIL midreset_abort: got dones=%0d writes=%0d required 0 0", done_cnt - d0, wr_cnt - w0);
        end
        poke(8'd2, 16'h0005);
        run_cmd(2'b11, 2'b01, 3'd2, 3'd0, 8'h12, 7'h00, 0, 0, lat, b1);
        checks++;
        if (lat != 4 + WBX || ANSWER !== 16'h0017) begin
            errors++; $display("FAIL midreset_fresh: got lat=%0d ans=%h required %0d 0017", lat, ANSWER, 4 + WBX);
        end
    endtask

    task automatic test_port_rules;
        checks++;
        if (port_err != 0) begin errors++; $display("FAIL port_rules: got %0d violations required 0", port_err); end
    endtask

    initial begin
        test_reset;
        test_immediate;
        test_register;
        test_direct_wrap_start_while_busy;
        test_indirect;
        test_illegal_op;
        test_reset_mid_command;
        test_port_rules;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
